// File: rtl/fp_mul_result_stage.sv
//==============================================================================
// Module      : fp_mul_result_stage
// Description : Registered IEEE-754 single-precision multiplier result stage.
//               Applies NaN/Inf/zero/overflow/underflow handling, valid/ready
//               output register, sticky exception flags and a delivery count.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fp_mul_result_stage #(
    parameter int FLAG_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic [31:0]       in_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [FLAG_W-1:0] out_flags,
    output logic [FLAG_W-1:0] sticky_flags,
    input  logic              flags_clr,
    output logic [CNT_W-1:0]  op_count
);

    localparam int c_invalid_bit   = 4;
    localparam int c_inf_bit       = 3;
    localparam int c_overflow_bit  = 2;
    localparam int c_underflow_bit = 1;
    localparam int c_zero_bit      = 0;

    localparam logic [31:0] c_qnan = 32'h7FC0_0000;

    // Operand classification
    logic [7:0] w_a_exp, w_b_exp;
    logic       w_a_man_nz, w_b_man_nz;
    logic       w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [7:0] w_a_ee, w_b_ee;
    logic [8:0] w_exp_sum;
    logic       w_sign;
    logic [7:0] w_res_exp;

    assign w_a_exp    = in_a[30:23];
    assign w_b_exp    = in_b[30:23];
    assign w_a_man_nz = |in_a[22:0];
    assign w_b_man_nz = |in_b[22:0];

    assign w_a_nan  = (w_a_exp == 8'hFF) &&  w_a_man_nz;
    assign w_b_nan  = (w_b_exp == 8'hFF) &&  w_b_man_nz;
    assign w_a_inf  = (w_a_exp == 8'hFF) && !w_a_man_nz;
    assign w_b_inf  = (w_b_exp == 8'hFF) && !w_b_man_nz;
    assign w_a_zero = (w_a_exp == 8'h00) && !w_a_man_nz;
    assign w_b_zero = (w_b_exp == 8'h00) && !w_b_man_nz;

    // Denormals carry an effective exponent of 1
    assign w_a_ee    = (w_a_exp == 8'h00) ? 8'd1 : w_a_exp;
    assign w_b_ee    = (w_b_exp == 8'h00) ? 8'd1 : w_b_exp;
    assign w_exp_sum = {1'b0, w_a_ee} + {1'b0, w_b_ee};
    assign w_sign    = in_a[31] ^ in_b[31];
    assign w_res_exp = in_result[30:23];

    logic [31:0]       w_res;
    logic [FLAG_W-1:0] w_flags;

    always_comb begin
        w_res   = in_result;
        w_flags = '0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_res                  = c_qnan;
            w_flags[c_invalid_bit] = 1'b1;
        end else if (w_a_inf || w_b_inf) begin
            w_res              = {w_sign, 8'hFF, 23'h0};
            w_flags[c_inf_bit] = 1'b1;
        end else if (w_a_zero || w_b_zero) begin
            w_res               = {w_sign, 31'h0};
            w_flags[c_zero_bit] = 1'b1;
        end else if ((w_exp_sum >= 9'd382) ||
                     ((w_exp_sum == 9'd381) && (w_res_exp == 8'hFF))) begin
            w_res                   = {w_sign, 8'hFF, 23'h0};
            w_flags[c_overflow_bit] = 1'b1;
            w_flags[c_inf_bit]      = 1'b1;
        end else if ((w_exp_sum <= 9'd126) ||
                     ((w_exp_sum == 9'd127) && (w_res_exp == 8'h00))) begin
            w_res                    = {w_sign, 31'h0};
            w_flags[c_underflow_bit] = 1'b1;
            w_flags[c_zero_bit]      = 1'b1;
        end
    end

    // Output register and bookkeeping
    logic              r_valid;
    logic [31:0]       r_result;
    logic [FLAG_W-1:0] r_flags;
    logic [FLAG_W-1:0] r_sticky;
    logic [CNT_W-1:0]  r_count;
    logic              w_accept;
    logic              w_xfer;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_xfer   = r_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
            r_sticky <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_valid  <= 1'b1;
                r_result <= w_res;
                r_flags  <= w_flags;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
            // A clear in the same cycle as a transfer keeps that transfer's flags
            r_sticky <= (flags_clr ? '0 : r_sticky) | (w_xfer ? r_flags : '0);
            if (w_xfer) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign out_valid    = r_valid;
    assign out_result   = r_result;
    assign out_flags    = r_flags;
    assign sticky_flags = r_sticky;
    assign op_count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_result_stage.sv
//==============================================================================
// Module      : tb_fp_mul_result_stage
// Description : Directed self-checking bench for fp_mul_result_stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fp_mul_result_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] in_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flags;
    logic [4:0]  sticky_flags;
    logic        flags_clr;
    logic [15:0] op_count;

    int n_chk = 0;
    int n_err = 0;
    int exp_cnt = 0;

    fp_mul_result_stage #(.FLAG_W(5), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_result    (in_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .sticky_flags (sticky_flags),
        .flags_clr    (flags_clr),
        .op_count     (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted operation with out_ready high; checks the registered output
    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic [31:0] er, input logic [4:0] ef);
        @(negedge clk);
        in_a      = a;
        in_b      = b;
        in_result = r;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_result"}, out_result, er);
        check({tag, "_flags"}, {27'b0, out_flags}, {27'b0, ef});
        exp_cnt++;
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
    endtask

    logic [15:0] held_cnt;

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_result = '0;
        out_ready = 1'b1;
        flags_clr = 1'b0;
        #3 rst_n = 1'b0;
        tick();
        tick();
        check("rst_valid",  {31'b0, out_valid}, 32'd0);
        check("rst_result", out_result, 32'd0);
        check("rst_flags",  {27'b0, out_flags}, 32'd0);
        check("rst_sticky", {27'b0, sticky_flags}, 32'd0);
        check("rst_count",  {16'b0, op_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Normal pass-through 2.0 x 3.0
        op("mul2x3", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 32'h40C0_0000, 5'b00000);
        tick();
        check("mul2x3_cnt",    {16'b0, op_count}, 32'd1);
        check("mul2x3_drop",   {31'b0, out_valid}, 32'd0);
        check("mul2x3_sticky", {27'b0, sticky_flags}, 32'd0);

        // Invalid cases
        op("nan", 32'h7FC0_0000, 32'h3F80_0000, 32'h1234_5678, 32'h7FC0_0000, 5'b10000);
        tick();
        check("nan_sticky", {27'b0, sticky_flags}, 32'h10);
        op("inf_x_zero", 32'h7F80_0000, 32'h8000_0000, 32'h0, 32'h7FC0_0000, 5'b10000);
        op("inf", 32'hFF80_0000, 32'h3F80_0000, 32'h0, 32'hFF80_0000, 5'b01000);
        op("zero", 32'h8000_0000, 32'h3F80_0000, 32'h5, 32'h8000_0000, 5'b00001);
        tick();
        check("mix_sticky", {27'b0, sticky_flags}, 32'h19);
        check("mix_cnt", {16'b0, op_count}, exp_cnt);
        clear_pulse();
        check("clr_sticky", {27'b0, sticky_flags}, 32'd0);

        // Overflow and its boundary at s == 381
        op("ovf_pos", 32'h7F00_0000, 32'h4000_0000, 32'hDEAD_BEEF, 32'h7F80_0000, 5'b01100);
        op("ovf_neg", 32'h7F00_0000, 32'hC000_0000, 32'hDEAD_BEEF, 32'hFF80_0000, 5'b01100);
        op("ovf_381", 32'h7E80_0000, 32'h4000_0000, 32'h7F80_0000, 32'h7F80_0000, 5'b01100);
        op("pass_381", 32'h7E80_0000, 32'h4000_0000, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 5'b00000);
        tick();
        check("ovf_sticky", {27'b0, sticky_flags}, 32'h0C);
        clear_pulse();

        // Underflow and its boundary at s == 127
        op("unf", 32'h0080_0000, 32'h0080_0000, 32'h0000_1234, 32'h0000_0000, 5'b00011);
        tick();
        check("unf_sticky", {27'b0, sticky_flags}, 32'h03);
        op("unf_127", 32'hBF00_0000, 32'h0080_0000, 32'h8040_0000, 32'h8000_0000, 5'b00011);
        op("pass_127", 32'h3F00_0000, 32'h0080_0000, 32'h0080_0000, 32'h0080_0000, 5'b00000);
        tick();
        check("unf_cnt", {16'b0, op_count}, exp_cnt);

        // Backpressure: result held, input stalled, count frozen
        @(negedge clk);
        out_ready = 1'b0;
        in_a      = 32'h4000_0000;
        in_b      = 32'h4040_0000;
        in_result = 32'h40C0_0000;
        in_valid  = 1'b1;
        tick();
        held_cnt  = op_count;
        in_a      = 32'h3F80_0000;
        in_b      = 32'h4000_0000;
        in_result = 32'h4000_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            check("bp_result",   out_result, 32'h40C0_0000);
            check("bp_cnt",      {16'b0, op_count}, {16'b0, held_cnt});
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", {31'b0, in_ready}, 32'd1);
        tick();
        check("bb1_result", out_result, 32'h4000_0000);
        check("bb1_cnt", {16'b0, op_count}, {16'b0, held_cnt + 16'd1});
        in_a      = 32'h4040_0000;
        in_b      = 32'h4040_0000;
        in_result = 32'h4110_0000;
        tick();
        check("bb2_result", out_result, 32'h4110_0000);
        check("bb2_cnt", {16'b0, op_count}, {16'b0, held_cnt + 16'd2});
        in_valid = 1'b0;
        tick();
        check("bb3_cnt", {16'b0, op_count}, {16'b0, held_cnt + 16'd3});
        check("bb3_valid", {31'b0, out_valid}, 32'd0);

        // Clear coincident with an overflow transfer keeps that transfer's flags
        op("ovf_clr", 32'h7F00_0000, 32'h4000_0000, 32'h0, 32'h7F80_0000, 5'b01100);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        check("clr_xfer_sticky", {27'b0, sticky_flags}, 32'h0C);

        // Asynchronous reset while a result is held
        op("pre_rst", 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 32'h40C0_0000, 5'b00000);
        rst_n = 1'b0;
        #1;
        check("arst_valid",  {31'b0, out_valid}, 32'd0);
        check("arst_sticky", {27'b0, sticky_flags}, 32'd0);
        check("arst_cnt",    {16'b0, op_count}, 32'd0);
        tick();
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp_mul_result_stage.md
Name: fp_mul_result_stage

Overview:
- Registered post-processing stage directly downstream of the combinational single-precision multiplier.
- Captures the multiplier's raw 32-bit result together with the original operands, then applies IEEE-754 special-case handling (NaN, Inf, zero, overflow, underflow).
- Produces a final result plus per-operation flags over a valid/ready handshake, and accumulates sticky exception flags for software.

Parameters:
- FLAG_W, 5, width of the flag vector; bit order {invalid, inf, overflow, underflow, zero}. Fixed at 5.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream operand/result valid
- in_ready  output  1  stage can accept
- in_a  input  32  operand A as presented to the multiplier
- in_b  input  32  operand B as presented to the multiplier
- in_result  input  32  raw multiplier output for in_a × in_b
- out_valid  output  1  final result valid
- out_ready  input  1  downstream accepts
- out_result  output  32  final IEEE-754 result
- out_flags  output  5  flags for out_result
- sticky_flags  output  5  OR of flags of all delivered results since last clear
- flags_clr  input  1  synchronous clear of sticky_flags
- op_count  output  CNT_W  count of delivered results

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_result=0, out_flags=0, sticky_flags=0, op_count=0.
- Single pipeline register; in_ready = !out_valid || out_ready, combinational.
- Accept when in_valid && in_ready. On the next edge out_valid=1 and out_result/out_flags are loaded. Latency is 1 cycle.
- Back-to-back throughput is 1 per cycle while out_ready=1.
- Transfer out occurs on out_valid && out_ready. If there is no simultaneous accept, out_valid clears.
- While out_valid && !out_ready: out_result and out_flags hold stable and in_ready=0.
- Classification per operand (e=bits[30:23], m=bits[22:0]):
  - NaN: e=FF, m≠0
  - Inf: e=FF, m=0
  - Zero: e=0, m=0
  - Effective exponent ee = (e==0) ? 1 : e
- Derived values: s = ee_a + ee_b (9-bit unsigned); sign = a[31]^b[31].
- Result selection, first match wins:
  1. Either operand NaN, or Inf×Zero → 32'h7FC00000; invalid=1.
  2. Either operand Inf → {sign, 8'hFF, 23'h0}; inf=1.
  3. Either operand Zero → {sign, 31'h0}; zero=1.
  4. s≥382, or (s==381 && in_result[30:23]==8'hFF) → {sign, 8'hFF, 23'h0}; overflow=1, inf=1.
  5. s≤126, or (s==127 && in_result[30:23]==8'h00) → {sign, 31'h0}; underflow=1, zero=1 (flush-to-zero).
  6. Otherwise → in_result unchanged; all flags 0.
- Sticky flags, on each edge:
  - sticky_flags = (flags_clr ? 0 : sticky_flags) | (transfer-out ? out_flags : 0).
  - A clear coincident with a transfer therefore keeps that transfer's flags.
- op_count increments on each transfer out and wraps at 2^CNT_W−1 → 0. It is not affected by flags_clr.
- Reset asserted mid-operation: the held result is discarded, out_valid drops immediately (async), no flags are retained.
- in_a, in_b and in_result are sampled only on accept; values at other times are ignored.

Test Plan:
- Normal 2.0×3.0: in_a=40000000, in_b=40400000, in_result=40C00000, out_ready=1 → one cycle later out_valid=1, out_result=40C00000, out_flags=0, op_count=1.
- NaN and invalid:
  - in_a=7FC00000, in_b=3F800000 → out_result=7FC00000, out_flags[invalid]=1.
  - in_a=7F800000, in_b=80000000 → out_result=7FC00000, invalid=1.
- Overflow:
  - in_a=7F000000, in_b=40000000 (s=382), in_result arbitrary → out_result=7F800000, overflow=1, inf=1.
  - With in_b=C0000000 → FF800000.
- Underflow: in_a=00800000, in_b=00800000 (s=2) → out_result=00000000, underflow=1, zero=1. Then sticky_flags=5'b00011.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_result stable, op_count unchanged. Raise out_ready → one transfer per cycle, op_count increments each cycle.
- Clear and reset:
  - Pulse flags_clr in the same cycle as an overflow transfer → sticky_flags=5'b01100 afterwards.
  - Assert rst_n=0 while out_valid=1 → out_valid=0 and sticky_flags=0 immediately.
